// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller: FSM states,
// predicted/actual outcome codes and the predictor index width.
package branch_resolve_ctrl_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } brc_state_t;

  localparam logic [1:0] PA_NT_NT = 2'b00;
  localparam logic [1:0] PA_NT_T  = 2'b01;
  localparam logic [1:0] PA_T_NT  = 2'b10;
  localparam logic [1:0] PA_T_T   = 2'b11;

  function automatic logic is_mispredict(input logic [1:0] pa);
    return (pa == PA_NT_T) || (pa == PA_T_NT);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_fifo.sv
// brc_fifo: in-order queue of {index, pred} for in-flight branches.
// Pointers wrap modulo DEPTH (power of two); clear empties the queue.
module brc_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           push,
  input  logic [IDX_W:0] push_data,
  input  logic           pop,
  input  logic           clear,
  output logic [IDX_W:0] head_data,
  output logic           full,
  output logic           empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: tracks in-flight predicted branches, strobes predictor
// updates and flushes/redirects fetch on a mispredict. BRC_STATS_EN adds Mispredict_count.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Issue_valid,
  input  logic [IDX_W-1:0] Issue_index,
  input  logic             Issue_pred,
  output logic             Issue_ready,
  input  logic             Resolve_valid,
  input  logic             Resolve_taken,
  input  logic [31:0]      Resolve_pc,
  output logic             Upd_valid,
  output logic [IDX_W-1:0] Upd_index,
  output logic [1:0]       Pred_actual,
  output logic             Flush,
  output logic             Redirect_valid,
  output logic [31:0]      Redirect_pc,
  output logic             Busy
`ifdef BRC_STATS_EN
  ,
  output logic [15:0]      Mispredict_count
`endif
);

  brc_state_t     state;
  brc_state_t     state_nxt;
  logic [3:0]     flush_cnt;
  logic           flush_done;
  logic [IDX_W:0] head_data;
  logic [IDX_W-1:0] head_idx;
  logic           head_pred;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           mispredict;

  logic             upd_vld_p1;
  logic [IDX_W-1:0] upd_idx_p1;
  logic [1:0]       pa_p1;
  logic             redir_vld_p1;
  logic [31:0]      redir_pc_p1;

  assign head_idx   = head_data[IDX_W:1];
  assign head_pred  = head_data[0];
  assign push       = Issue_valid && Issue_ready;
  assign pop        = (state == ST_IDLE) && Resolve_valid && !empty;
  assign mispredict = pop && is_mispredict({head_pred, Resolve_taken});
  assign flush_done = (flush_cnt == 4'(FLUSH_CYCLES - 1));

  brc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push),
    .push_data ({Issue_index, Issue_pred}),
    .pop       (pop),
    .clear     (mispredict),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (mispredict) state_nxt = ST_FLUSH;
      ST_FLUSH:   if (flush_done) state_nxt = ST_RECOVER;
      ST_RECOVER: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Issue_ready = (state == ST_IDLE) && (!full || Resolve_valid);
    Flush       = (state == ST_FLUSH);
    Busy        = !empty || (state != ST_IDLE);
  end

  // Stage p1: resolve results registered one cycle after Resolve_valid.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      upd_vld_p1   <= 1'b0;
      upd_idx_p1   <= '0;
      pa_p1        <= PA_NT_NT;
      redir_vld_p1 <= 1'b0;
      redir_pc_p1  <= '0;
    end else begin
      upd_vld_p1   <= pop;
      redir_vld_p1 <= mispredict;
      if (pop) begin
        upd_idx_p1 <= head_idx;
        pa_p1      <= {head_pred, Resolve_taken};
      end
      if (mispredict) redir_pc_p1 <= Resolve_pc;
    end
  end

  assign Upd_valid      = upd_vld_p1;
  assign Upd_index      = upd_idx_p1;
  assign Pred_actual    = pa_p1;
  assign Redirect_valid = redir_vld_p1;
  assign Redirect_pc    = redir_pc_p1;

`ifdef BRC_STATS_EN
  logic [15:0] mis_cnt_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset)           mis_cnt_p1 <= '0;
    else if (mispredict) mis_cnt_p1 <= sat_inc16(mis_cnt_p1);
  end

  assign Mispredict_count = mis_cnt_p1;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Issue_valid;
  logic [3:0]  Issue_index;
  logic        Issue_pred;
  logic        Issue_ready;
  logic        Resolve_valid;
  logic        Resolve_taken;
  logic [31:0] Resolve_pc;
  logic        Upd_valid;
  logic [3:0]  Upd_index;
  logic [1:0]  Pred_actual;
  logic        Flush;
  logic        Redirect_valid;
  logic [31:0] Redirect_pc;
  logic        Busy;
`ifdef BRC_STATS_EN
  logic [15:0] Mispredict_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Issue_valid    (Issue_valid),
    .Issue_index    (Issue_index),
    .Issue_pred     (Issue_pred),
    .Issue_ready    (Issue_ready),
    .Resolve_valid  (Resolve_valid),
    .Resolve_taken  (Resolve_taken),
    .Resolve_pc     (Resolve_pc),
    .Upd_valid      (Upd_valid),
    .Upd_index      (Upd_index),
    .Pred_actual    (Pred_actual),
    .Flush          (Flush),
    .Redirect_valid (Redirect_valid),
    .Redirect_pc    (Redirect_pc),
    .Busy           (Busy)
`ifdef BRC_STATS_EN
    ,
    .Mispredict_count (Mispredict_count)
`endif
  );

  task automatic set_in(input logic iv, input logic [3:0] ii, input logic ip,
                        input logic rv, input logic rt, input logic [31:0] rpc);
    Issue_valid   = iv;
    Issue_index   = ii;
    Issue_pred    = ip;
    Resolve_valid = rv;
    Resolve_taken = rt;
    Resolve_pc    = rpc;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(1, 4'd2, 0, 0, 0, 0);
    tick();
    // Reset must win over a simultaneous mispredicting resolve and an issue.
    Reset = 1'b1;
    set_in(1, 4'd9, 1, 1, 1, 32'hDEAD_BEEF);
    tick();
    Reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Upd_valid !== 1'b0) begin fails++; $display("FAIL rst_upd_valid got %0b want 0", Upd_valid); end
    tests++; if (Upd_index !== 4'd0) begin fails++; $display("FAIL rst_upd_index got %0d want 0", Upd_index); end
    tests++; if (Pred_actual !== 2'b00) begin fails++; $display("FAIL rst_pred_actual got %b want 00", Pred_actual); end
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL rst_flush got %0b want 0", Flush); end
    tests++; if (Redirect_valid !== 1'b0) begin fails++; $display("FAIL rst_redirect_valid got %0b want 0", Redirect_valid); end
    tests++; if (Redirect_pc !== 32'd0) begin fails++; $display("FAIL rst_redirect_pc got %h want 0", Redirect_pc); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b want 0", Busy); end
    tests++; if (Issue_ready !== 1'b1) begin fails++; $display("FAIL rst_issue_ready got %0b want 1", Issue_ready); end
  endtask

  task automatic test_correct();
    do_reset();
    set_in(1, 4'd3, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 1, 32'h0000_1234);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Upd_valid !== 1'b1) begin fails++; $display("FAIL corr_upd_valid got %0b want 1", Upd_valid); end
    tests++; if (Upd_index !== 4'd3) begin fails++; $display("FAIL corr_upd_index got %0d want 3", Upd_index); end
    tests++; if (Pred_actual !== 2'b11) begin fails++; $display("FAIL corr_pred_actual got %b want 11", Pred_actual); end
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL corr_flush got %0b want 0", Flush); end
    tests++; if (Redirect_valid !== 1'b0) begin fails++; $display("FAIL corr_redirect got %0b want 0", Redirect_valid); end
    tick();
    tests++; if (Upd_valid !== 1'b0) begin fails++; $display("FAIL corr_upd_strobe got %0b want 0", Upd_valid); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL corr_busy got %0b want 0", Busy); end
  endtask

  task automatic test_mispredict();
    int low = 0;
    int fl  = 0;
    do_reset();
    set_in(1, 4'd5, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 1, 32'h0000_0040);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Upd_valid !== 1'b1) begin fails++; $display("FAIL mis_upd_valid got %0b want 1", Upd_valid); end
    tests++; if (Pred_actual !== 2'b01) begin fails++; $display("FAIL mis_pred_actual got %b want 01", Pred_actual); end
    tests++; if (Redirect_valid !== 1'b1) begin fails++; $display("FAIL mis_redirect_valid got %0b want 1", Redirect_valid); end
    tests++; if (Redirect_pc !== 32'h40) begin fails++; $display("FAIL mis_redirect_pc got %h want 00000040", Redirect_pc); end
    for (int k = 0; k < 5; k++) begin
      if (!Issue_ready) low++;
      if (Flush) fl++;
      tick();
      if (k == 0) begin
        tests++; if (Redirect_valid !== 1'b0) begin fails++; $display("FAIL mis_redirect_pulse got %0b want 0", Redirect_valid); end
        tests++; if (Redirect_pc !== 32'h40) begin fails++; $display("FAIL mis_redirect_hold got %h want 00000040", Redirect_pc); end
      end
    end
    tests++; if (fl != FC) begin fails++; $display("FAIL mis_flush_cycles got %0d want %0d", fl, FC); end
    tests++; if (low != FC + 1) begin fails++; $display("FAIL mis_ready_low got %0d want %0d", low, FC + 1); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL mis_busy got %0b want 0", Busy); end
  endtask

  task automatic test_full();
    logic [3:0] exp_idx [4];
    exp_idx[0] = 4'd2; exp_idx[1] = 4'd3; exp_idx[2] = 4'd4; exp_idx[3] = 4'd6;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 4'(i), 1, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Issue_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b want 0", Issue_ready); end
    set_in(1, 4'd6, 1, 1, 1, 0);
    #1;
    tests++; if (Issue_ready !== 1'b1) begin fails++; $display("FAIL full_ready_w_resolve got %0b want 1", Issue_ready); end
    tick();
    tests++; if (Upd_index !== 4'd1) begin fails++; $display("FAIL full_first_pop got %0d want 1", Upd_index); end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Issue_ready !== 1'b0) begin fails++; $display("FAIL full_still_full got %0b want 0", Issue_ready); end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, 1, 0);
      tick();
      tests++;
      if (Upd_valid !== 1'b1 || Upd_index !== exp_idx[i]) begin
        fails++; $display("FAIL full_drain%0d got v=%0b idx=%0d want v=1 idx=%0d", i, Upd_valid, Upd_index, exp_idx[i]);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL full_busy_end got %0b want 0", Busy); end
  endtask

  task automatic test_empty_resolve();
    do_reset();
    set_in(0, 0, 0, 1, 0, 32'h99);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    tests++; if (Upd_valid !== 1'b0) begin fails++; $display("FAIL empty_upd_valid got %0b want 0", Upd_valid); end
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL empty_flush got %0b want 0", Flush); end
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL empty_busy got %0b want 0", Busy); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_in(1, 4'd9, 0, 0, 0, 0); tick();
    set_in(1, 4'd7, 1, 0, 0, 0); tick();
    set_in(1, 4'd8, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 1, 32'h100);
    tick();
    tests++; if (Flush !== 1'b1) begin fails++; $display("FAIL fr_flush1 got %0b want 1", Flush); end
    for (int k = 0; k < FC + 1; k++) begin
      set_in(0, 0, 0, 1, 1, 0);
      tick();
      tests++; if (Upd_valid !== 1'b0) begin fails++; $display("FAIL fr_ignored%0d got %0b want 0", k, Upd_valid); end
    end
    set_in(0, 0, 0, 1, 1, 0);
    #1;
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL fr_cleared_busy got %0b want 0", Busy); end
    tick();
    tests++; if (Upd_valid !== 1'b0) begin fails++; $display("FAIL fr_cleared_upd got %0b want 0", Upd_valid); end
    set_in(1, 4'd4, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 0, 32'h200);
    tick();
    tests++; if (Redirect_pc !== 32'h200) begin fails++; $display("FAIL fr_redirect_pc got %h want 00000200", Redirect_pc); end
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    tests++; if (Flush !== 1'b1) begin fails++; $display("FAIL fr_flush2 got %0b want 1", Flush); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests++; if (Flush !== 1'b0) begin fails++; $display("FAIL fr_reset_flush got %0b want 0", Flush); end
    tests++; if (Issue_ready !== 1'b1) begin fails++; $display("FAIL fr_reset_ready got %0b want 1", Issue_ready); end
  endtask

`ifdef BRC_STATS_EN
  task automatic test_stats();
    logic [1:0] seq [5];
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00; seq[4] = 2'b01;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 4'(i), seq[i][1], 0, 0, 0); tick();
      set_in(0, 0, 0, 1, seq[i][0], 32'(i * 4)); tick();
      set_in(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < FC + 2; k++) tick();
    end
    tests++; if (Mispredict_count !== 16'd3) begin fails++; $display("FAIL stats_count got %0d want 3", Mispredict_count); end
  endtask
`endif

  task automatic test_random();
    int q[$];
    int lock = 0;
    int h;
    logic exp_uv = 0, exp_rv = 0, mis;
    logic [3:0] exp_ui = 0;
    logic [1:0] exp_pa = 0;
    logic [31:0] exp_pc = 0;
    logic iv, ip, rv, rt, rdy_e, busy_e, fl_e;
    logic [3:0] ii;
    logic [31:0] rpc;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      iv  = ($urandom_range(0, 99) < 55);
      ii  = 4'($urandom_range(0, 15));
      ip  = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 99) < 45);
      rpc = $urandom;
      if (q.size() > 0 && $urandom_range(0, 99) < 80) rt = q[0][0];
      else rt = 1'($urandom_range(0, 1));
      set_in(iv, ii, ip, rv, rt, rpc);
      #1;
      rdy_e  = (lock == 0) && (q.size() < DEPTH || rv);
      busy_e = (q.size() > 0) || (lock > 0);
      fl_e   = (lock > 1);
      tests++; if (Issue_ready !== rdy_e) begin fails++; $display("FAIL rnd_ready c=%0d got %0b want %0b", c, Issue_ready, rdy_e); end
      tests++; if (Busy !== busy_e) begin fails++; $display("FAIL rnd_busy c=%0d got %0b want %0b", c, Busy, busy_e); end
      tests++; if (Flush !== fl_e) begin fails++; $display("FAIL rnd_flush c=%0d got %0b want %0b", c, Flush, fl_e); end
      exp_uv = 1'b0;
      exp_rv = 1'b0;
      mis    = 1'b0;
      if (lock == 0 && rv && q.size() > 0) begin
        h      = q.pop_front();
        exp_uv = 1'b1;
        exp_ui = 4'(h / 2);
        exp_pa = {h[0], rt};
        mis    = (h[0] != rt);
      end
      if (iv && rdy_e) q.push_back(int'(ii) * 2 + int'(ip));
      if (mis) begin
        q.delete();
        lock   = FC + 1;
        exp_rv = 1'b1;
        exp_pc = rpc;
      end else if (lock > 0) begin
        lock--;
      end
      tick();
      tests++; if (Upd_valid !== exp_uv) begin fails++; $display("FAIL rnd_upd_valid c=%0d got %0b want %0b", c, Upd_valid, exp_uv); end
      tests++; if (Upd_index !== exp_ui) begin fails++; $display("FAIL rnd_upd_index c=%0d got %0d want %0d", c, Upd_index, exp_ui); end
      tests++; if (Pred_actual !== exp_pa) begin fails++; $display("FAIL rnd_pred_actual c=%0d got %b want %b", c, Pred_actual, exp_pa); end
      tests++; if (Redirect_valid !== exp_rv) begin fails++; $display("FAIL rnd_redirect_valid c=%0d got %0b want %0b", c, Redirect_valid, exp_rv); end
      tests++; if (Redirect_pc !== exp_pc) begin fails++; $display("FAIL rnd_redirect_pc c=%0d got %h want %h", c, Redirect_pc, exp_pc); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_empty_resolve();
    test_flush_reset();
`ifdef BRC_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
